lc3b_mem_responder: RTL
=======================

// Module: lc3b_mem_responder
// PURPOSE
//  Memory-side responder for the LC-3b CPU memory handshake (mem_read/mem_write -> mem_resp).
//  Holds a byte-write-enabled 16-bit word array and answers each request after a fixed,
//  parameterised latency, modelling physical memory or a lower cache level.
//  Sits opposite the datapath/cache initiator; the testbench and FPGA top both instantiate it.
// PARAMETERS
//  DEPTH    256  number of 16-bit words; power of two; index = mem_address[$clog2(DEPTH):1]
//  LATENCY  4    cycles from request-sampling edge to mem_resp high; legal range 1..15
// PORTS
//  clk              in   1   clock; all state updates on the rising edge
//  rst              in   1   synchronous, active-high reset
//  mem_read         in   1   read request; held by the initiator until mem_resp
//  mem_write        in   1   write request; held by the initiator until mem_resp
//  mem_address      in   16  byte address (lc3b_word); bit 0 ignored
//  mem_wdata        in   16  write data (lc3b_word)
//  mem_byte_enable  in   2   lc3b_mem_wmask; [1] = high byte, [0] = low byte
//  mem_rdata        out  16  read data; valid while mem_resp = 1, held until next read response
//  mem_resp         out  1   one-cycle completion pulse
//  mem_err          out  1   only with LC3B_MEM_OOR_ERR_EN; qualified by mem_resp
// BEHAVIOUR
//  Reset: state IDLE, latency counter 0, mem_resp 0, mem_rdata 16'h0000, mem_err 0.
//   Array contents are NOT reset.
//  FSM:
//   IDLE: on an edge with mem_read|mem_write = 1, latch address, wdata, byte_enable and op
//    (write wins if both asserted). LATENCY = 1 -> RESP; else -> WAIT, counter = LATENCY-1.
//   WAIT: counter decrements each edge; at 1 -> RESP.
//   RESP: mem_resp = 1 for exactly one cycle, then -> IDLE unconditionally.
//  Latency: request sampled at edge t -> mem_resp high in cycle t+LATENCY.
//  Write commit: byte lanes with enable = 1 are written on the edge entering RESP; others keep
//   old value. byte_enable = 2'b00 completes with no array change.
//  Read: array word is registered into mem_rdata on the edge entering RESP.
//  Latched request fields are used; input changes after sampling are ignored until IDLE.
//  Back-to-back: the IDLE cycle after RESP is mandatory, so a request still held during RESP
//   is never re-captured; a new request is sampled at the earliest in the IDLE cycle.
//  Reset mid-operation: returns to IDLE the next edge, no mem_resp; a write not yet committed
//   is dropped.
// CONFIGURATION
//  LC3B_MEM_OOR_ERR_EN defined:
//   - Word index >= DEPTH (upper address bits non-zero) is out of range.
//   - OOR write: completes with no array change.
//   - OOR read: returns mem_rdata 16'h0000.
//   - mem_err = 1 in the RESP cycle only, 0 otherwise.
//  Not defined: mem_err port absent; upper address bits ignored, so addresses wrap modulo DEPTH.
// STRUCTURE
//  lc3b_types gains:
//   - lc3b_mem_state enum {mem_idle, mem_wait, mem_resp_st}
//   - lc3b_mem_wmask constant values MEM_WMASK_LO = 2'b01, MEM_WMASK_HI = 2'b10, MEM_WMASK_W = 2'b11
//  Sub-module lc3b_mem_array: DEPTH x 16 byte-enabled synchronous RAM with registered read.
//   The responder keeps the FSM, counter and OOR check.
// TESTING
//  1 Word write/read: write 16'hBEEF @16'h0010, be 11; read @16'h0010 -> rdata 16'hBEEF,
//    resp exactly LATENCY cycles after each sampling edge, 1 cycle wide.
//  2 Byte lanes: word @16'h0020 = 16'h1234; write 16'hAB00, be 10 -> read 16'hAB34;
//    write 16'h00CD, be 01 -> read 16'hABCD; be 00 -> unchanged.
//  3 Held request: initiator holds mem_read through RESP and drops it after -> exactly one resp;
//    back-to-back reads of @0 and @2 each take LATENCY+1 cycles incl. the IDLE gap.
//  4 Both read+write asserted with wdata 16'h5555 @16'h0030 -> treated as write;
//    following read -> 16'h5555.
//  5 Reset at cycle 2 of a LATENCY=4 write of 16'h7777 @16'h0040 -> no resp,
//    word keeps its prior value (16'h0101).
//  6 Config, DEPTH=256:
//    - _EN on: read @16'h0200 -> rdata 0, mem_err 1; write there -> mem_err 1, @16'h0000 unchanged.
//    - _EN off: write 16'h9999 @16'h0200 -> read @16'h0000 = 16'h9999.
//  Run 1-3 at LATENCY = 1 and 15.

Source files
------------

// File: rtl/lc3b_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder_pkg
// Shared types for the LC-3b memory responder slice:
//   lc3b_word       16-bit data/address word
//   lc3b_mem_wmask  2-bit byte-lane write mask ([1] = high byte, [0] = low byte)
//   lc3b_mem_state  responder FSM states
//   addr_oor()      out-of-range check on a byte address for a given index width
// ---------------------------------------------------------------------------
package lc3b_mem_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam lc3b_mem_wmask MEM_WMASK_LO = 2'b01;
    localparam lc3b_mem_wmask MEM_WMASK_HI = 2'b10;
    localparam lc3b_mem_wmask MEM_WMASK_W  = 2'b11;

    typedef enum logic [1:0] {
        mem_idle    = 2'b00,
        mem_wait    = 2'b01,
        mem_resp_st = 2'b10
    } lc3b_mem_state;

    // True when any address bit above the word index is set. Bit 0 is the
    // byte select and bits [aw:1] form the word index.
    function automatic logic addr_oor(input lc3b_word addr, input int unsigned aw);
        lc3b_word upper_s;
        upper_s = addr >> (aw + 32'd1);
        return (upper_s != 16'h0000);
    endfunction

endpackage

// File: rtl/lc3b_mem_responder_if.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder_if
// LC-3b memory handshake bundle between an initiator (datapath/cache) and a
// memory-side responder.
//   mem_read, mem_write        request strobes, held until mem_resp
//   mem_address, mem_wdata     byte address and write data
//   mem_byte_enable            byte-lane write mask
//   mem_rdata, mem_resp        read data and one-cycle completion pulse
//   mem_err                    present only when LC3B_MEM_OOR_ERR_EN is defined
// Modports: master = initiator side, slave = responder side.
// ---------------------------------------------------------------------------
interface lc3b_mem_responder_if;
    import lc3b_mem_responder_pkg::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_rdata;
    logic          mem_resp;
`ifdef LC3B_MEM_OOR_ERR_EN
    logic          mem_err;
`endif

    modport master (
        output mem_read,
        output mem_write,
        output mem_address,
        output mem_wdata,
        output mem_byte_enable,
        input  mem_rdata,
`ifdef LC3B_MEM_OOR_ERR_EN
        input  mem_err,
`endif
        input  mem_resp
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_address,
        input  mem_wdata,
        input  mem_byte_enable,
        output mem_rdata,
`ifdef LC3B_MEM_OOR_ERR_EN
        output mem_err,
`endif
        output mem_resp
    );

endinterface

// File: rtl/lc3b_mem_responder_array.sv
// ---------------------------------------------------------------------------
// lc3b_mem_array
// DEPTH x 16-bit synchronous RAM with per-byte write enables and a registered
// read port. The read register is the only reset state; contents are not
// reset.
//   clk, rst   clock and synchronous active-high reset (read register only)
//   idx        word index shared by write and read
//   we, be     write strobe and byte-lane mask
//   wdata      write data
//   re         load rdata from the addressed word
//   rzero      load rdata with zero (takes priority over re)
//   rdata      registered read data, held between loads
// ---------------------------------------------------------------------------
module lc3b_mem_array
    import lc3b_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] idx,
    input  logic          we,
    input  lc3b_mem_wmask be,
    input  lc3b_word      wdata,
    input  logic          re,
    input  logic          rzero,
    output lc3b_word      rdata
);

    // Byte lanes kept in separate arrays so each lane writes independently.
    logic [7:0] mem_lo_r [DEPTH];
    logic [7:0] mem_hi_r [DEPTH];
    lc3b_word   rdata_r;

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        if (we && be[0]) begin
            mem_lo_r[idx] <= wdata[7:0];
        end
        if (we && be[1]) begin
            mem_hi_r[idx] <= wdata[15:8];
        end
    end

    // Registered read port; holds its value until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 16'h0000;
        end else if (rzero) begin
            rdata_r <= 16'h0000;
        end else if (re) begin
            rdata_r <= {mem_hi_r[idx], mem_lo_r[idx]};
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/lc3b_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3b_mem_responder
// Memory-side responder for the LC-3b mem_read/mem_write -> mem_resp
// handshake. Each request is answered LATENCY cycles after the edge that
// samples it, with a one-cycle mem_resp pulse followed by a mandatory IDLE
// cycle.
//   Parameters: DEPTH (words, power of two), LATENCY (1..15)
//   clk        clock, all state on the rising edge
//   rst        synchronous, active-high reset
//   bus        lc3b_mem_responder_if.slave handshake bundle
// Optional feature macro LC3B_MEM_OOR_ERR_EN: addresses whose word index is
// >= DEPTH are rejected (writes dropped, reads return zero) and flagged on
// mem_err during the response cycle. Without it, upper address bits are
// ignored and addresses wrap modulo DEPTH.
// ---------------------------------------------------------------------------
module lc3b_mem_responder
    import lc3b_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    lc3b_mem_responder_if.slave  bus
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 32'd1);

    lc3b_mem_state state_r;
    lc3b_mem_state state_next_s;
    logic [3:0]    cnt_r;
    logic [3:0]    cnt_next_s;
    logic          resp_r;

    // Request fields latched at the sampling edge.
    logic          op_wr_r;
    logic [AW-1:0] idx_r;
    lc3b_word      wdata_r;
    lc3b_mem_wmask be_r;
`ifdef LC3B_MEM_OOR_ERR_EN
    logic          oor_r;
    logic          err_r;
`endif

    // Effective request: live inputs while IDLE (needed when LATENCY = 1
    // enters RESP on the sampling edge itself), latched copy otherwise.
    logic          req_s;
    logic          capture_s;
    logic          cur_wr_s;
    logic [AW-1:0] cur_idx_s;
    lc3b_word      cur_wdata_s;
    lc3b_mem_wmask cur_be_s;
    logic          cur_oor_s;
    logic          enter_resp_s;
    logic          arr_we_s;
    logic          arr_re_s;
    logic          arr_rzero_s;
    lc3b_word      arr_rdata_s;

    // Select the request fields that the current cycle acts on.
    always_comb begin
        req_s       = bus.mem_read | bus.mem_write;
        capture_s   = 1'b0;
        cur_wr_s    = op_wr_r;
        cur_idx_s   = idx_r;
        cur_wdata_s = wdata_r;
        cur_be_s    = be_r;
        cur_oor_s   = 1'b0;
        if (state_r == mem_idle) begin
            capture_s   = req_s;
            cur_wr_s    = bus.mem_write;
            cur_idx_s   = bus.mem_address[AW:1];
            cur_wdata_s = bus.mem_wdata;
            cur_be_s    = bus.mem_byte_enable;
`ifdef LC3B_MEM_OOR_ERR_EN
            cur_oor_s   = addr_oor(bus.mem_address, AW);
`endif
        end else begin
`ifdef LC3B_MEM_OOR_ERR_EN
            cur_oor_s   = oor_r;
`endif
        end
    end

    // FSM next-state and latency countdown.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            mem_idle: begin
                if (req_s) begin
                    if (LATENCY == 32'd1) begin
                        state_next_s = mem_resp_st;
                    end else begin
                        state_next_s = mem_wait;
                        cnt_next_s   = LAT_M1;
                    end
                end else begin
                    state_next_s = mem_idle;
                end
            end
            mem_wait: begin
                if (cnt_r == 4'd1) begin
                    state_next_s = mem_resp_st;
                    cnt_next_s   = 4'd0;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            mem_resp_st: begin
                // The IDLE cycle after RESP is unconditional, so a request
                // still held here is never re-captured.
                state_next_s = mem_idle;
                cnt_next_s   = 4'd0;
            end
            default: begin
                state_next_s = mem_idle;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // RESP is only ever entered from IDLE or WAIT, so the next state alone
    // marks the commit edge. Reset at that edge drops the access.
    always_comb begin
        enter_resp_s = (state_next_s == mem_resp_st) && !rst;
        arr_we_s     = enter_resp_s &&  cur_wr_s && !cur_oor_s;
        arr_re_s     = enter_resp_s && !cur_wr_s && !cur_oor_s;
        arr_rzero_s  = enter_resp_s && !cur_wr_s &&  cur_oor_s;
    end

    // FSM state, counter and response flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= mem_idle;
            cnt_r   <= 4'd0;
            resp_r  <= 1'b0;
`ifdef LC3B_MEM_OOR_ERR_EN
            err_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            resp_r  <= (state_next_s == mem_resp_st);
`ifdef LC3B_MEM_OOR_ERR_EN
            err_r   <= (state_next_s == mem_resp_st) && cur_oor_s;
`endif
        end
    end

    // Latch request fields at the sampling edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_r <= 1'b0;
            idx_r   <= '0;
            wdata_r <= 16'h0000;
            be_r    <= 2'b00;
`ifdef LC3B_MEM_OOR_ERR_EN
            oor_r   <= 1'b0;
`endif
        end else if (capture_s) begin
            op_wr_r <= cur_wr_s;
            idx_r   <= cur_idx_s;
            wdata_r <= cur_wdata_s;
            be_r    <= cur_be_s;
`ifdef LC3B_MEM_OOR_ERR_EN
            oor_r   <= cur_oor_s;
`endif
        end
    end

    lc3b_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .idx   (cur_idx_s),
        .we    (arr_we_s),
        .be    (cur_be_s),
        .wdata (cur_wdata_s),
        .re    (arr_re_s),
        .rzero (arr_rzero_s),
        .rdata (arr_rdata_s)
    );

    assign bus.mem_resp  = resp_r;
    assign bus.mem_rdata = arr_rdata_s;
`ifdef LC3B_MEM_OOR_ERR_EN
    assign bus.mem_err   = err_r;
`endif

endmodule
